// File: rtl/div_unit_pkg.sv
// Shared widths, constants, state encoding and helpers for the divide unit.
package div_unit_pkg;

  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;

  localparam logic [WORD_W-1:0]  ZERO_WORD  = '0;
  localparam logic [DWORD_W-1:0] ZERO_DWORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Magnitude of an operand: two's-complement absolute value for signed
  // operations, the raw bits otherwise. 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  function automatic logic [WORD_W-1:0] abs_word(input logic [WORD_W-1:0] value,
                                                 input logic               is_signed);
    return (is_signed && value[WORD_W-1]) ? (ZERO_WORD - value) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not borrow.
module div_step
  import div_unit_pkg::*;
(
  input  logic [WORD_W:0]   partial,
  input  logic [WORD_W-1:0] divisor,
  output logic [WORD_W-1:0] rem_next,
  output logic              q_bit
);

  logic [WORD_W+1:0] diff;
  logic              diff_unused;

  // The partial remainder is 33 bits, so the subtraction carries an extra
  // borrow bit; a surviving difference is always below the divisor and fits
  // in 32 bits, leaving bit 32 of the difference unused.
  always_comb begin
    diff     = {1'b0, partial} - {2'b00, divisor};
    q_bit    = ~diff[WORD_W+1];
    rem_next = q_bit ? diff[WORD_W-1:0] : partial[WORD_W-1:0];
  end

  assign diff_unused = diff[WORD_W];

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider with a fixed 33-cycle latency.
// result = {remainder, quotient}, feeding the HI/LO registers directly.
module div_unit
  import div_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_op,
  input  logic               cancel,
  input  logic [WORD_W-1:0]  dividend,
  input  logic [WORD_W-1:0]  divisor,
  output logic               busy,
  output logic               done,
  output logic [DWORD_W-1:0] result
);

  div_state_t        state;
  logic [4:0]        count;
  logic [WORD_W-1:0] rem_q;
  logic [WORD_W-1:0] quo_q;
  logic [WORD_W-1:0] dvs_mag_q;
  logic              dvd_neg_q;
  logic              dvs_neg_q;
  logic              sgn_q;
  logic              dvz_q;

  logic [WORD_W:0]   step_partial;
  logic [WORD_W-1:0] step_rem;
  logic              step_bit;
  logic [WORD_W-1:0] quo_final;
  logic [WORD_W-1:0] quo_fix;
  logic [WORD_W-1:0] rem_fix;

  // The quotient register starts out holding the dividend magnitude; its MSB
  // is shifted into the partial remainder each step while quotient bits
  // enter at the bottom.
  assign step_partial = {rem_q, quo_q[WORD_W-1]};

  div_step u_step (
    .partial  (step_partial),
    .divisor  (dvs_mag_q),
    .rem_next (step_rem),
    .q_bit    (step_bit)
  );

  // Sign correction for the final step; divide-by-zero forces an all-ones
  // quotient while the remainder correction restores the raw dividend.
  always_comb begin
    quo_final = {quo_q[WORD_W-2:0], step_bit};
    if (dvz_q) begin
      quo_fix = '1;
    end else if (sgn_q && (dvd_neg_q ^ dvs_neg_q)) begin
      quo_fix = ZERO_WORD - quo_final;
    end else begin
      quo_fix = quo_final;
    end
    rem_fix = (sgn_q && dvd_neg_q) ? (ZERO_WORD - step_rem) : step_rem;
  end

  // Control FSM and datapath registers; reset beats cancel, cancel beats start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= 5'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= ZERO_DWORD;
      rem_q     <= ZERO_WORD;
      quo_q     <= ZERO_WORD;
      dvs_mag_q <= ZERO_WORD;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      sgn_q     <= 1'b0;
      dvz_q     <= 1'b0;
    end else if (cancel) begin
      state <= ST_IDLE;
      count <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= ST_CALC;
            busy      <= 1'b1;
            count     <= 5'd0;
            rem_q     <= ZERO_WORD;
            quo_q     <= abs_word(dividend, signed_op);
            dvs_mag_q <= abs_word(divisor, signed_op);
            dvd_neg_q <= signed_op & dividend[WORD_W-1];
            dvs_neg_q <= signed_op & divisor[WORD_W-1];
            sgn_q     <= signed_op;
            dvz_q     <= (divisor == ZERO_WORD);
          end
        end
        ST_CALC: begin
          rem_q <= step_rem;
          quo_q <= quo_final;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            result <= {rem_fix, quo_fix};
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic cases, latency,
// cancel, start-while-busy, start+cancel and mid-operation reset.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int checks = 0;
  int fails  = 0;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .cancel    (cancel),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds start for exactly one rising edge, then
  // returns at the negedge of the first cycle after acceptance.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    signed_op = sgn;
    dividend  = a;
    divisor   = b;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Waits (bounded) for done; 'elapsed' is the number of cycles since the
  // accepting edge at the moment of the call. done must land at cycle 33.
  task automatic waitDone(input string tag, input int elapsed, input logic [63:0] exp);
    int lat;
    lat = elapsed;
    while (done !== 1'b1 && lat < 45) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd33);
    checkOutput({tag, "_result"}, result, exp);
    @(negedge clk);
    checkOutput({tag, "_done_after"}, {63'd0, done}, 64'd0);
    checkOutput({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, "_result_hold"}, result, exp);
  endtask

  task automatic runDivide(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
    applyStimulus(sgn, a, b);
    checkOutput({tag, "_busy_k1"}, {63'd0, busy}, 64'd1);
    checkOutput({tag, "_done_k1"}, {63'd0, done}, 64'd0);
    waitDone(tag, 1, exp);
  endtask

  initial begin
    int pulses;
    int busy_seen;

    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    cancel    = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_result", result, 64'd0);
    rst = 1'b0;

    $display("[TB] arithmetic cases");
    runDivide("udiv_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    runDivide("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    runDivide("sdiv_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    runDivide("udiv_big_divisor", 1'b0, 32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF_00000001);
    runDivide("udiv_by_zero", 1'b0, 32'h12345678, 32'h0, 64'h12345678_FFFFFFFF);
    runDivide("sdiv_by_zero", 1'b1, 32'h12345678, 32'h0, 64'h12345678_FFFFFFFF);
    runDivide("sdiv_neg_by_zero", 1'b1, 32'hFFFFFFF9, 32'h0, 64'hFFFFFFF9_FFFFFFFF);
    runDivide("sdiv_overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

    $display("[TB] cancel at iteration 10");
    applyStimulus(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancel_busy", {63'd0, busy}, 64'd0);
    checkOutput("cancel_done", {63'd0, done}, 64'd0);
    checkOutput("cancel_result_kept", result, 64'h00000000_80000000);
    runDivide("after_cancel", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);

    $display("[TB] start while busy");
    applyStimulus(1'b0, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clk);
    start    = 1'b0;
    waitDone("busy_start", 6, 64'h00000001_0000014D);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checkOutput("busy_start_no_queue", 64'(pulses), 64'd0);

    $display("[TB] start with cancel in idle");
    start     = 1'b1;
    cancel    = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd3;
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    pulses    = 0;
    busy_seen = 0;
    repeat (40) begin
      if (busy === 1'b1) busy_seen++;
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    checkOutput("startcancel_busy", 64'(busy_seen), 64'd0);
    checkOutput("startcancel_done", 64'(pulses), 64'd0);
    checkOutput("startcancel_result", result, 64'h00000001_0000014D);

    $display("[TB] reset at iteration 20");
    applyStimulus(1'b0, 32'hDEADBEEF, 32'h10);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrst_done", {63'd0, done}, 64'd0);
    checkOutput("midrst_result", result, 64'd0);
    runDivide("after_rst", 1'b0, 32'hDEADBEEF, 32'h10, 64'h0000000F_0DEADBEE);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; the 32-bit operand width and 64-bit result width are fixed.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request a divide; sampled only in IDLE.
REQ-006 signed_op  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
REQ-007 cancel  in  1  pipeline flush; aborts any operation in progress.
REQ-008 dividend  in  32  dividend operand; sampled with start.
REQ-009 divisor  in  32  divisor operand; sampled with start.
REQ-010 busy  out  1  high whenever state != IDLE.
REQ-011 done  out  1  one-cycle pulse; drives the HI/LO write enable directly.
REQ-012 result  out  64  {remainder[63:32], quotient[31:0]}; maps to {HI, LO}.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE.
REQ-014 Transitions:
- IDLE -> CALC on start && !cancel.
- CALC -> DONE after 32 iterations.
- DONE -> IDLE unconditionally.
- Any state -> IDLE on cancel.
REQ-015 At the accepting edge, the block SHALL latch the operand magnitudes (two's-complement absolute values when signed_op = 1, raw values otherwise), both operand signs, signed_op, and a divide-by-zero flag, and SHALL clear the iteration counter to 0.
REQ-016 Each CALC edge SHALL perform one restoring shift/subtract step, producing one quotient bit, MSB first.
- Counter is 5 bits.
- Counter wraps 31 -> 0 on the transition to DONE.
REQ-017 On the CALC -> DONE edge, result SHALL be registered with sign correction applied:
- quotient is negated iff signed_op and the dividend and divisor signs differ;
- remainder is negated iff signed_op and the dividend is negative (truncating division).
REQ-018 done SHALL be high exactly in the DONE cycle, 33 cycles after the start-sampling edge; latency is fixed for all operands.
REQ-019 result SHALL hold its value until the next DONE entry or reset.
REQ-020 start while busy = 1 SHALL be ignored, with no queuing.
REQ-021 start and cancel high in the same IDLE cycle: cancel wins and the request is dropped.
REQ-022 cancel in DONE SHALL NOT suppress that cycle's done pulse; it only forces IDLE, which happens next edge regardless.
REQ-023 Divisor = 0 (either mode) SHALL give quotient = 0xFFFFFFFF and remainder = the raw dividend, with the normal 33-cycle latency.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient = 0x80000000 and remainder = 0x00000000, without a trap.
REQ-025 Intermediate subtraction SHALL be 33 bits wide, so unsigned divisors >= 0x80000000 are handled correctly.

Reset
REQ-026 rst SHALL take priority over cancel and start.
REQ-027 On rst, the block SHALL set state = IDLE, counter = 0, result = 64'h0, busy = 0, done = 0.
REQ-028 rst asserted mid-CALC SHALL abort the operation with no done pulse; a start is accepted on the first edge after rst deasserts.

Structure
REQ-029 Word/DWord width macros, the ZeroWord/ZeroDWord constants and the FSM state encodings SHALL live in the shared defines include.
REQ-030 One combinational sub-module, div_step, SHALL be used.
- Inputs: partial remainder and divisor.
- Outputs: next partial remainder and quotient bit.
- Everything else stays in div_unit.

Verification
REQ-031 Unsigned 100 / 7, start at edge k -> busy = 1 from k+1; done = 1 only at cycle k+33; result = 0x00000002_0000000E.
REQ-032 Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> result = 0xFFFFFFFF_FFFFFFFD; unsigned 0xFFFFFFFF / 0x80000000 -> result = 0x7FFFFFFF_00000001.
REQ-033 Divide by zero, signed and unsigned, with dividend 0x12345678 -> result = 0x12345678_FFFFFFFF after 33 cycles; signed 0x80000000 / -1 -> result = 0x00000000_80000000.
REQ-034 cancel at CALC iteration 10 -> IDLE next edge, busy = 0, no done, result unchanged; an immediate new start completes correctly.
REQ-035 start pulses during CALC with different operands -> ignored; the original result is returned; start plus cancel in IDLE -> no operation.
REQ-036 rst at iteration 20 -> all outputs 0 next cycle and no done; a start one cycle later completes in 33 cycles.
